rr_arb_mux: RTL
===============

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 2, select/channel-index width; SHALL equal ceil(log2(CHANNELS)).
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 In_Data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 In_Valid  input  CHANNELS  per-channel valid.
REQ-008 In_Ready  output  CHANNELS  per-channel ready; combinational.
REQ-009 Mode  input  1  0 = fixed select via Sel, 1 = round-robin arbitration.
REQ-010 Sel  input  SEL_W  channel index used when Mode=0.
REQ-011 Out_Data  output  WIDTH  registered selected data.
REQ-012 Out_Valid  output  1  registered output valid.
REQ-013 Out_Chan  output  SEL_W  registered index of the channel that supplied Out_Data.
REQ-014 Out_Ready  input  1  downstream ready.

Function
REQ-015 Load = ~Out_Valid | Out_Ready; the output register SHALL accept a new word only when Load=1.
REQ-016 A transfer on channel k SHALL occur exactly when In_Valid[k] & In_Ready[k]; a transfer on the output SHALL occur exactly when Out_Valid & Out_Ready.
REQ-017 In_Ready SHALL be one-hot or zero: In_Ready[g]=1 only for the granted channel g, and only when Load=1.
REQ-018 Mode=0: grant = Sel if Sel < CHANNELS and In_Valid[Sel]=1; otherwise no grant; In_Valid of other channels SHALL be ignored.
REQ-019 Mode=1: grant = first k with In_Valid[k]=1, searching Ptr, Ptr+1, ... modulo CHANNELS; no grant if In_Valid is all zero.
REQ-020 Ptr (SEL_W bits, internal) SHALL update to (g+1) mod CHANNELS on every Mode=1 transfer, wrapping from CHANNELS-1 to 0; unchanged otherwise, including all Mode=0 cycles.
REQ-021 On a transfer, next-cycle Out_Data = channel g data, Out_Chan = g, Out_Valid = 1 (latency exactly one cycle).
REQ-022 Load=1 with no grant SHALL set Out_Valid=0 next cycle; Out_Data and Out_Chan SHALL hold their prior values.
REQ-023 Load=0 (Out_Valid=1, Out_Ready=0) SHALL hold Out_Data, Out_Chan, Out_Valid, Ptr unchanged and drive In_Ready all zero.
REQ-024 Simultaneous output drain and new grant in one cycle SHALL sustain one word per cycle with no bubble.
REQ-025 Mode and Sel SHALL be sampled combinationally each cycle; a change takes effect on the same cycle's grant.

Reset
REQ-026 Reset=1 at a rising edge SHALL set Out_Valid=0, Out_Data=0, Out_Chan=0, Ptr=0, overriding any concurrent transfer.
REQ-027 While Reset=1, In_Ready SHALL be all zero; reset asserted mid-stall SHALL discard the held word.

Verification
REQ-028 Reset, Mode=1, In_Valid=4'b1111, data k=k+1, Out_Ready=1 -> Out_Chan sequence 0,1,2,3,0 on consecutive cycles, Out_Data 1,2,3,4,1, Out_Valid held 1.
REQ-029 Mode=0, Sel=2, In_Valid=4'b1011 -> In_Ready=0000, Out_Valid=0; raise In_Valid[2] with data 4'hA -> next cycle Out_Data=4'hA, Out_Chan=2.
REQ-030 Out_Valid=1 with Out_Data=4'h5, Out_Ready=0 for 3 cycles, all In_Valid=1 -> In_Ready=0000, Out_Data stays 4'h5, Ptr unchanged; Out_Ready=1 -> next word loaded in same cycle.
REQ-031 Mode=1, Ptr=3, In_Valid=4'b0101 -> grant channel 0, Ptr becomes 1; next cycle grant channel 2, Ptr becomes 3.
REQ-032 Reset asserted while Out_Valid=1 and Out_Ready=0 -> next cycle Out_Valid=0, Out_Data=0, Out_Chan=0; first post-reset Mode=1 grant with all valid is channel 0.
REQ-033 CHANNELS=3, SEL_W=2, WIDTH=8, Mode=0, Sel=3, all valid -> no grant, Out_Valid=0; Mode=1 -> Out_Chan wraps 0,1,2,0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one registered output stage.
//
// Selects one input channel per cycle, either a fixed channel given by sel
// (mode=0) or by round-robin search starting at an internal pointer (mode=1).
// The chosen word is captured into the output register one cycle later.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_data    in   CHANNELS*WIDTH packed data; channel k at [k*WIDTH +: WIDTH]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready, combinational, one-hot or zero
//   mode       in   0 = fixed select via sel, 1 = round-robin
//   sel        in   channel index used when mode=0
//   out_data   out  registered selected data
//   out_valid  out  registered output valid
//   out_chan   out  registered index of the channel that supplied out_data
//   out_ready  in   downstream ready
module rr_arb_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  if (SEL_W != $clog2(CHANNELS)) begin : g_bad_sel_w
    $error("rr_arb_mux: SEL_W must equal clog2(CHANNELS)");
  end

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

  logic             load;
  logic             xfer;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Output register can take a word when empty or being drained this cycle.
  assign load = ~out_valid_q | out_ready;

  // Grant selection. Loops compare against constant k so no variable-width
  // index is ever applied to in_valid; sel values >= CHANNELS never match.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!mode) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if ((32'(sel) == k) && in_valid[k]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        // ptr_q < CHANNELS, so a single subtract implements the modulo.
        idx = 32'(ptr_q) + i;
        if (idx >= CHANNELS) begin
          idx = idx - CHANNELS;
        end
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (!grant_vld && (k == idx) && in_valid[k]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(k);
          end
        end
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(grant_idx) == k) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the granted channel, and never during reset so that
  // no upstream word is consumed on a cycle whose capture reset discards.
  always_comb begin
    in_ready = '0;
    if (!reset && load && grant_vld) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (32'(grant_idx) == k) begin
          in_ready[k] = 1'b1;
        end
      end
    end
  end

  assign xfer = grant_vld & load & ~reset;

  // Pointer moves past the winner on round-robin transfers only.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer && mode) begin
      if (32'(grant_idx) == CHANNELS - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + SEL_W'(1);
      end
    end
  end

  // Output stage: capture on transfer, go empty on load without a grant,
  // otherwise hold. Data/chan keep their last values when going empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (load) begin
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_chan_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule
